ahb_ext_arbiter: RTL

Two-master AHB-Lite arbiter that shares the SoC's external-memory AHB port between the Wally SoC external master (M0, qualified by its HSELEXT) and an FPGA-side loader/debug master (M1). It sits between the SoC wrapper and the external memory slave. It provides round-robin arbitration with burst and lock protection. A one-entry hold register per master lets a losing master's accepted address phase be parked and replayed, so neither master violates AHB-Lite pipelining.

---
 rtl/ahb_ext_arbiter.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_ext_arbiter.sv
// ahb_ext_arbiter
// Two-master AHB-Lite arbiter in front of the external-memory slave port.
// M0 is the SoC external master (qualified by HSELEXT), M1 is the FPGA-side
// loader/debug master. Round-robin arbitration with burst/lock protection.
// Each master has a one-entry hold register. An address phase accepted from
// a master that cannot reach the slave in that cycle is parked there and
// replayed later.
//
// Ports
//   HCLK, HRESETn               clock, asynchronous active-low reset
//   MxHSEL..MxHMASTLOCK         master x address phase (x = 0, 1)
//   MxHWDATA, MxHWSTRB          master x write data / byte strobes (data phase)
//   MxHREADYOUT, MxHRESP        ready / response returned to master x
//   MxHRDATA                    read data (slave read data broadcast)
//   SHSEL..SHMASTLOCK           slave address phase
//   SHWDATA, SHWSTRB            slave write data phase
//   SHRDATA, SHREADY, SHRESP    slave response
module ahb_ext_arbiter #(
  parameter int PA_BITS = 34,
  parameter int AHBW    = 64
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  // master 0
  input  logic                M0HSEL,
  input  logic [PA_BITS-1:0]  M0HADDR,
  input  logic [1:0]          M0HTRANS,
  input  logic                M0HWRITE,
  input  logic [2:0]          M0HSIZE,
  input  logic [2:0]          M0HBURST,
  input  logic                M0HMASTLOCK,
  input  logic [AHBW-1:0]     M0HWDATA,
  input  logic [AHBW/8-1:0]   M0HWSTRB,
  output logic                M0HREADYOUT,
  output logic                M0HRESP,
  output logic [AHBW-1:0]     M0HRDATA,
  // master 1
  input  logic                M1HSEL,
  input  logic [PA_BITS-1:0]  M1HADDR,
  input  logic [1:0]          M1HTRANS,
  input  logic                M1HWRITE,
  input  logic [2:0]          M1HSIZE,
  input  logic [2:0]          M1HBURST,
  input  logic                M1HMASTLOCK,
  input  logic [AHBW-1:0]     M1HWDATA,
  input  logic [AHBW/8-1:0]   M1HWSTRB,
  output logic                M1HREADYOUT,
  output logic                M1HRESP,
  output logic [AHBW-1:0]     M1HRDATA,
  // slave
  output logic                SHSEL,
  output logic [PA_BITS-1:0]  SHADDR,
  output logic [1:0]          SHTRANS,
  output logic                SHWRITE,
  output logic [2:0]          SHSIZE,
  output logic [2:0]          SHBURST,
  output logic                SHMASTLOCK,
  output logic [AHBW-1:0]     SHWDATA,
  output logic [AHBW/8-1:0]   SHWSTRB,
  input  logic [AHBW-1:0]     SHRDATA,
  input  logic                SHREADY,
  input  logic                SHRESP
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  typedef struct packed {
    logic [PA_BITS-1:0] addr;
    logic [1:0]         trans;
    logic               write;
    logic [2:0]         size;
    logic [2:0]         burst;
    logic               mastlock;
  } aphase_t;

  // Master-indexed views of the input ports.
  aphase_t           live  [2];
  logic [1:0]        sel;
  logic [AHBW-1:0]   wdata [2];
  logic [AHBW/8-1:0] wstrb [2];

  assign live[0]  = {M0HADDR, M0HTRANS, M0HWRITE, M0HSIZE, M0HBURST, M0HMASTLOCK};
  assign live[1]  = {M1HADDR, M1HTRANS, M1HWRITE, M1HSIZE, M1HBURST, M1HMASTLOCK};
  assign sel      = {M1HSEL, M0HSEL};
  assign wdata[0] = M0HWDATA;
  assign wdata[1] = M1HWDATA;
  assign wstrb[0] = M0HWSTRB;
  assign wstrb[1] = M1HWSTRB;

  // State
  aphase_t    hold_q [2];
  logic [1:0] hold_v_q;
  logic       owner_q;
  logic       last_q;
  logic       dp_valid_q;
  logic       dp_master_q;
  logic       dp_write_q;
  logic [3:0] burst_cnt_q;

  // Combinational
  logic [1:0] rdy;
  logic [1:0] live_req;
  logic [1:0] pend;
  logic       lock;
  logic       gnt;
  logic       issue_v;
  aphase_t    ap;

  // Ready back to each master, and its live request. A request is only
  // sampled while that master sees HREADYOUT high.
  always_comb begin
    rdy      = '1;
    live_req = '0;
    pend     = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (dp_valid_q && (dp_master_q == 1'(i)))
        rdy[i] = SHREADY;
      else
        rdy[i] = ~hold_v_q[i];
      live_req[i] = HRESETn & sel[i] & live[i].trans[1] & rdy[i];
      pend[i]     = hold_v_q[i] | live_req[i];
    end
  end

  // Ownership stays put mid-burst, while the owner signals SEQ/BUSY, or
  // while it asserts HMASTLOCK.
  always_comb begin
    lock = (burst_cnt_q != '0) |
           (sel[owner_q] & (live[owner_q].trans[0] | live[owner_q].mastlock));
  end

  // Arbitration takes effect in the current cycle: gnt is the owner whose
  // hold or live request drives the slave right now.
  always_comb begin
    gnt = owner_q;
    if (SHREADY && !lock && pend[~owner_q]) begin
      if (!pend[owner_q])
        gnt = ~owner_q;
      else
        gnt = ~last_q;
    end
  end

  // Slave address phase: a parked transfer always goes before a live one.
  always_comb begin
    ap      = '0;
    issue_v = 1'b0;
    if (hold_v_q[gnt]) begin
      ap      = hold_q[gnt];
      issue_v = 1'b1;
    end else if (live_req[gnt]) begin
      ap      = live[gnt];
      issue_v = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      hold_v_q    <= '0;
      for (int unsigned i = 0; i < 2; i++)
        hold_q[i] <= '0;
      dp_valid_q  <= 1'b0;
      dp_master_q <= 1'b0;
      dp_write_q  <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      owner_q <= gnt;
      if (gnt != owner_q)
        last_q <= gnt;

      // A hold leaves when its replay is accepted. A live request that
      // cannot go straight to the slave this cycle is parked.
      for (int unsigned i = 0; i < 2; i++) begin
        if (hold_v_q[i]) begin
          if ((gnt == 1'(i)) && SHREADY)
            hold_v_q[i] <= 1'b0;
        end else if (live_req[i] && !((gnt == 1'(i)) && SHREADY)) begin
          hold_v_q[i] <= 1'b1;
          hold_q[i]   <= live[i];
        end
      end

      if (SHREADY) begin
        dp_valid_q  <= issue_v;
        dp_master_q <= gnt;
        dp_write_q  <= ap.write;
      end

      // Remaining beats of a fixed-length burst: INCR4/WRAP4 -> 3, 8 -> 7,
      // 16 -> 15. SINGLE and INCR leave the counter at zero.
      if (SHREADY && issue_v) begin
        if (ap.trans == TR_NONSEQ) begin
          case (ap.burst[2:1])
            2'b01:   burst_cnt_q <= 4'd3;
            2'b10:   burst_cnt_q <= 4'd7;
            2'b11:   burst_cnt_q <= 4'd15;
            default: burst_cnt_q <= 4'd0;
          endcase
        end else if ((ap.trans == TR_SEQ) && (burst_cnt_q != '0)) begin
          burst_cnt_q <= burst_cnt_q - 4'd1;
        end
      end
    end
  end

  // Slave side
  assign SHSEL      = issue_v;
  assign SHADDR     = ap.addr;
  assign SHTRANS    = ap.trans;
  assign SHWRITE    = ap.write;
  assign SHSIZE     = ap.size;
  assign SHBURST    = ap.burst;
  assign SHMASTLOCK = ap.mastlock;

  // Write data follows the data-phase owner. It is forced to zero outside
  // write data phases so the slave never sees stray strobes.
  always_comb begin
    SHWDATA = '0;
    SHWSTRB = '0;
    if (dp_valid_q && dp_write_q) begin
      SHWDATA = wdata[dp_master_q];
      SHWSTRB = wstrb[dp_master_q];
    end
  end

  // Master side
  assign M0HREADYOUT = rdy[0];
  assign M1HREADYOUT = rdy[1];
  assign M0HRESP     = dp_valid_q & ~dp_master_q & SHRESP;
  assign M1HRESP     = dp_valid_q &  dp_master_q & SHRESP;
  assign M0HRDATA    = SHRDATA;
  assign M1HRDATA    = SHRDATA;

endmodule
